// File: rtl/aes_uart_frame_loader_if.sv
// aes_uart_frame_loader_if: UART RX byte strobe in, 128-bit plaintext/key block handshake out.
interface aes_uart_frame_loader_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         blk_ready;
    logic         blk_valid;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;
    modport master (
        output rx_data, rx_valid, blk_ready,
        input  blk_valid, plaintext, key, busy, err, err_code
    );
    modport slave (
        input  rx_data, rx_valid, blk_ready,
        output blk_valid, plaintext, key, busy, err, err_code
    );
endinterface

// File: rtl/aes_uart_frame_loader.sv
// aes_uart_frame_loader: hunts a header byte, then collects 16 plaintext + 16 key bytes (MSB first) into a block.
// Define AES_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte, verified in a CHECK state.
module aes_uart_frame_loader #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input logic                    clk,
    input logic                    rst_n,
    aes_uart_frame_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    typedef enum logic [2:0] {IDLE, LOAD_PT, LOAD_KEY, CHECK, PRESENT} state_t;
    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic [TW-1:0] timer;
    logic [127:0]  pt_sr, key_sr, key_nx;
    logic          loading, shifting, last, tmo, ovr, ck_bad;
    logic [1:0]    code_nx;
    assign loading  = state inside {LOAD_PT, LOAD_KEY, CHECK};
    assign shifting = bus.rx_valid && (state == LOAD_PT || state == LOAD_KEY);
    assign last     = cnt == 4'd15;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo      = loading && !bus.rx_valid && timer == T_LAST;
    assign ovr      = state == PRESENT && bus.rx_valid;
    assign key_nx   = {key_sr[119:0], bus.rx_data};
`ifdef AES_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    assign csum_ok = csum == bus.rx_data;
    assign ck_bad  = state == CHECK && bus.rx_valid && !csum_ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) csum <= '0;
        else if (state == IDLE) csum <= '0;
        else if (shifting) csum <= csum ^ bus.rx_data;
`else
    assign ck_bad = 1'b0;
`endif
    assign code_nx = tmo ? 2'b01 : ovr ? 2'b10 : ck_bad ? 2'b11 : 2'b00;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (tmo) state_nx = IDLE;
        else case (state)
            IDLE:     if (bus.rx_valid && bus.rx_data == HEADER_BYTE) state_nx = LOAD_PT;
            LOAD_PT:  if (bus.rx_valid && last) state_nx = LOAD_KEY;
`ifdef AES_LOADER_CHECKSUM_EN
            LOAD_KEY: if (bus.rx_valid && last) state_nx = CHECK;
            CHECK:    if (bus.rx_valid) state_nx = csum_ok ? PRESENT : IDLE;
`else
            LOAD_KEY: if (bus.rx_valid && last) state_nx = PRESENT;
`endif
            PRESENT:  if (bus.blk_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.blk_valid = state == PRESENT;
        bus.busy      = state != IDLE;
    end

    // Outputs are loaded only on entry to PRESENT so they stay stable while the next frame streams in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            timer         <= '0;
            pt_sr         <= '0;
            key_sr        <= '0;
            bus.plaintext <= '0;
            bus.key       <= '0;
            bus.err       <= 1'b0;
            bus.err_code  <= 2'b00;
        end else begin
            cnt   <= state_nx == IDLE ? 4'd0 : cnt + 4'(shifting);
            timer <= loading && !bus.rx_valid && !tmo ? timer + 1'b1 : '0;
            if (shifting && state == LOAD_PT) pt_sr <= {pt_sr[119:0], bus.rx_data};
            if (shifting && state == LOAD_KEY) key_sr <= key_nx;
            if (state_nx == PRESENT && state != PRESENT) begin
                bus.plaintext <= pt_sr;
                bus.key       <= state == LOAD_KEY ? key_nx : key_sr;
            end
            bus.err      <= |code_nx;
            bus.err_code <= code_nx;
        end
    end
endmodule
